// File: rtl/bcd_to_bin_seq.sv
// Six-digit BCD to 20-bit binary converter using reverse double-dabble, one step per clock.
// Latency: 20 clocks from the accepting start edge to done; an invalid digit reports on the next cycle.
// Backpressure: none; start is ignored while busy, so the caller must wait for done before the next start.
module bcd_to_bin_seq (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  bcd_digit_0,
   input  logic [3:0]  bcd_digit_1,
   input  logic [3:0]  bcd_digit_2,
   input  logic [3:0]  bcd_digit_3,
   input  logic [3:0]  bcd_digit_4,
   input  logic [3:0]  bcd_digit_5,
   output logic [19:0] bin_number,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic {S_IDLE, S_CONVERT} state_t;

   state_t      state_q, state_d;
   logic [23:0] bcd_work_q, bcd_work_d;
   logic [19:0] bin_work_q, bin_work_d;
   logic [4:0]  iter_q, iter_d;
   logic [19:0] bin_number_q, bin_number_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        err_q, err_d;

   logic [43:0] shifted;
   logic [23:0] bcd_corr;
   logic        digit_bad;

   // One reverse double-dabble step: shift the whole pair right, then pull each BCD nibble back by 3 if >= 8.
   always_comb begin
      shifted  = {bcd_work_q, bin_work_q} >> 1;
      bcd_corr = shifted[43:20];
      for (int i = 0; i < 6; i++) begin
         if (shifted[20 + 4*i + 3]) begin
            bcd_corr[4*i +: 4] = shifted[20 + 4*i +: 4] - 4'd3;
         end
      end
   end

   // Any captured nibble above 9 rejects the whole request.
   always_comb begin
      digit_bad = (bcd_digit_0 > 4'd9) || (bcd_digit_1 > 4'd9) || (bcd_digit_2 > 4'd9) ||
                  (bcd_digit_3 > 4'd9) || (bcd_digit_4 > 4'd9) || (bcd_digit_5 > 4'd9);
   end

   // Next-state and output logic; done is a pulse, everything else holds by default.
   always_comb begin
      state_d      = state_q;
      bcd_work_d   = bcd_work_q;
      bin_work_d   = bin_work_q;
      iter_d       = iter_q;
      bin_number_d = bin_number_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      err_d        = err_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (digit_bad) begin
                  bin_number_d = 20'd0;
                  err_d        = 1'b1;
                  done_d       = 1'b1;
               end else begin
                  bcd_work_d = {bcd_digit_5, bcd_digit_4, bcd_digit_3,
                                bcd_digit_2, bcd_digit_1, bcd_digit_0};
                  bin_work_d = 20'd0;
                  iter_d     = 5'd0;
                  busy_d     = 1'b1;
                  state_d    = S_CONVERT;
               end
            end
         end
         S_CONVERT: begin
            bcd_work_d = bcd_corr;
            bin_work_d = shifted[19:0];
            iter_d     = iter_q + 5'd1;
            if (iter_q == 5'd19) begin
               bin_number_d = shifted[19:0];
               err_d        = 1'b0;
               done_d       = 1'b1;
               busy_d       = 1'b0;
               state_d      = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and result registers; reset clears everything including the last result.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         bcd_work_q   <= 24'd0;
         bin_work_q   <= 20'd0;
         iter_q       <= 5'd0;
         bin_number_q <= 20'd0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         bcd_work_q   <= bcd_work_d;
         bin_work_q   <= bin_work_d;
         iter_q       <= iter_d;
         bin_number_q <= bin_number_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

   assign bin_number = bin_number_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Scoreboard bench for bcd_to_bin_seq: stimulus pushes expected results, a monitor pops them on done.
module tb_bcd_to_bin_seq;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  d0 = 4'd0, d1 = 4'd0, d2 = 4'd0, d3 = 4'd0, d4 = 4'd0, d5 = 4'd0;
   logic [19:0] bin_number;
   logic        busy, done, err;

   bcd_to_bin_seq dut (
      .clk(clk), .reset(reset), .start(start),
      .bcd_digit_0(d0), .bcd_digit_1(d1), .bcd_digit_2(d2),
      .bcd_digit_3(d3), .bcd_digit_4(d4), .bcd_digit_5(d5),
      .bin_number(bin_number), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [19:0] bin;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t        exp_q[$];
   int          comp = 0;
   int          mism = 0;
   int          cyc = 0;
   int          done_cnt = 0;
   int          busy_cnt = 0;
   logic [19:0] last_bin = 20'd0;
   logic        last_err = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      comp++;
      if (act !== expv) begin
         mism++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, expv, $time);
      end
   endtask

   // Monitor: pops one expectation per done pulse; checks hold behaviour between pulses.
   always @(negedge clk) begin
      if (reset) begin
         busy_cnt = 0;
         last_bin = 20'd0;
         last_err = 1'b0;
      end else begin
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
               comp++;
               mism++;
               $display("FAIL unexpected_done: got done=1 expected no done (t=%0t)", $time);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("bin_number", bin_number, e.bin);
               chk("err", err, e.err);
               chk("done_cycle", cyc, e.cyc);
               chk("busy_on_done", busy, 0);
               chk("busy_cycles", busy_cnt, e.err ? 0 : 20);
               if (!e.err) chk("bcd_work_zero", dut.bcd_work_q, 0);
               last_bin = e.bin;
               last_err = e.err;
            end
            busy_cnt = 0;
         end else begin
            chk("bin_hold", bin_number, last_bin);
            chk("err_hold", err, last_err);
         end
      end
   end

   task automatic issue(input logic [3:0] a5, a4, a3, a2, a1, a0,
                        input logic [19:0] eb, input logic ee, input bit push, output int e0);
      exp_t e;
      @(negedge clk);
      {d5, d4, d3, d2, d1, d0} = {a5, a4, a3, a2, a1, a0};
      start = 1'b1;
      e0 = cyc + 1;
      if (push) begin
         e.bin = eb;
         e.err = ee;
         e.cyc = e0 + (ee ? 0 : 20);
         exp_q.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int n);
      int t = 0;
      while (done_cnt < n && t < 100) begin
         @(posedge clk);
         t++;
      end
      if (done_cnt < n) begin
         comp++;
         mism++;
         $display("FAIL done_timeout: got %0d done pulses expected %0d", done_cnt, n);
      end
      @(posedge clk);
   endtask

   initial begin
      int e0;
      // Reset state
      #7;
      chk("rst_bin", bin_number, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      @(negedge clk);
      reset = 1'b0;

      issue(4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 20'hF423F, 1'b0, 1'b1, e0);
      wait_done(1);
      issue(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 20'h1E240, 1'b0, 1'b1, e0);
      wait_done(2);
      issue(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 20'h00000, 1'b0, 1'b1, e0);
      wait_done(3);
      // Invalid digit in position 3
      issue(4'd0, 4'd0, 4'hA, 4'd0, 4'd0, 4'd0, 20'h00000, 1'b1, 1'b1, e0);
      wait_done(4);
      issue(4'd0, 4'd0, 4'd0, 4'd0, 4'd4, 4'd2, 20'h0002A, 1'b0, 1'b1, e0);
      wait_done(5);

      // start re-pulsed mid-run with different digits
      issue(4'd0, 4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 20'h00064, 1'b0, 1'b1, e0);
      while (cyc < e0 + 4) @(negedge clk);
      start = 1'b1; {d5, d4, d3, d2, d1, d0} = {6{4'd9}};
      @(negedge clk);
      start = 1'b0; {d5, d4, d3, d2, d1, d0} = {6{4'd3}};
      while (cyc < e0 + 11) @(negedge clk);
      start = 1'b1; {d5, d4, d3, d2, d1, d0} = {4'd0, 4'd0, 4'hB, 4'd0, 4'd0, 4'd0};
      @(negedge clk);
      start = 1'b0;
      wait_done(6);

      // Reset mid-conversion: outputs clear asynchronously, no done follows
      issue(4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 20'h0, 1'b0, 1'b0, e0);
      while (cyc < e0 + 10) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_bin", bin_number, 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      repeat (30) @(negedge clk);
      chk("no_done_after_reset", done_cnt, 6);
      issue(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 20'h00001, 1'b0, 1'b1, e0);
      wait_done(7);

      // Back-to-back with start held high
      begin
         exp_t e;
         @(negedge clk);
         {d5, d4, d3, d2, d1, d0} = {4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd7};
         start = 1'b1;
         e0 = cyc + 1;
         e.bin = 20'h00007; e.err = 1'b0; e.cyc = e0 + 20;
         exp_q.push_back(e);
         e.bin = 20'h00008; e.err = 1'b0; e.cyc = e0 + 41;
         exp_q.push_back(e);
         @(negedge clk);
         d0 = 4'd8;
         while (cyc < e0 + 21) @(negedge clk);
         start = 1'b0;
      end
      wait_done(9);

      repeat (5) @(negedge clk);
      chk("queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", comp, mism);
      $finish;
   end

endmodule
